unit_pkt_rx: RTL and testbench

Unit-side receiver for the byte-wide arbiter-to-unit bus. It sits at the input of every computing unit. It buffers the incoming stream (data, ctrl marker and write strobe) in a small FIFO and drives almost-full and ready back to the arbiter. It parses data packets into config, ID and length fields plus a key-memory write stream, and decodes broadcast init packets.

---
 rtl/unit_pkt_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_unit_pkt_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/unit_pkt_rx.sv
// Unit-side receiver for the arbiter-to-unit byte bus: a FWFT input FIFO feeding
// a packet parser that extracts config/ID/length fields, key writes and init commands.
//
// state    | meaning
// IDLE     | waiting for a header byte (ctrl=1)
// INIT_DUP | expecting the duplicate copy of an init byte
// CFG      | 24 config bytes (cfg_cnt, salt_len, salt)
// IDS      | 8 ID bytes
// KEYLEN   | 1 key length byte
// PAD      | 7 discarded pad bytes
// KEY      | key bytes streamed to key memory up to last_addr
// DONE     | packet complete, pkt_valid held until pkt_ack
module unit_pkt_rx #(
  parameter int WORD_MAX_LEN = 64,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [7:0]                      in_data,
  input  logic                            in_ctrl,
  input  logic                            in_wr_en,
  output logic                            in_afull,
  output logic                            in_ready,
  output logic [31:0]                     cfg_cnt,
  output logic [31:0]                     salt_len,
  output logic [127:0]                    salt,
  output logic [63:0]                     ids,
  output logic [$clog2(WORD_MAX_LEN):0]   key_len,
  output logic                            key_wr_en,
  output logic [$clog2(WORD_MAX_LEN)-1:0] key_wr_addr,
  output logic [7:0]                      key_wr_data,
  output logic                            pkt_valid,
  input  logic                            pkt_ack,
  output logic                            init_valid,
  output logic [4:0]                      init_data,
  output logic                            err
);
  localparam int AW = $clog2(WORD_MAX_LEN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] AFULL_C = (PW+1)'(FIFO_DEPTH - 4);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT_DUP, ST_CFG, ST_IDS, ST_KEYLEN, ST_PAD, ST_KEY, ST_DONE
  } state_t;

  logic [8:0]   mem_q [FIFO_DEPTH];
  logic [PW:0]  wr_ptr_q, rd_ptr_q, count;
  logic         full, empty, push, pop, ovf;
  logic [7:0]   hd_data;
  logic         hd_ctrl;

  state_t       state_q, state_d;
  logic [4:0]   byte_cnt_q, byte_cnt_d;
  logic [191:0] cfg_q, cfg_d;
  logic [63:0]  ids_q, ids_d;
  logic [AW:0]  key_len_q, key_len_d;
  logic [AW-1:0] last_addr_q, last_addr_d, key_addr_q, key_addr_d;
  logic [AW-1:0] key_wr_addr_q, key_wr_addr_d;
  logic [7:0]   key_wr_data_q, key_wr_data_d;
  logic         key_wr_en_q, key_wr_en_d;
  logic [4:0]   init_data_q, init_data_d;
  logic         init_valid_q, init_valid_d;
  logic         pkt_valid_q, pkt_valid_d;
  logic         err_q, err_d;
  logic         in_afull_q, in_ready_q;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push    = in_wr_en & ~full;
  assign ovf     = in_wr_en & full;
  assign hd_data = mem_q[rd_ptr_q[PW-1:0]][7:0];
  assign hd_ctrl = mem_q[rd_ptr_q[PW-1:0]][8];

  // FIFO storage is flushed by the pointer reset, so the array itself needs none.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {in_ctrl, in_data};
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    cfg_d         = cfg_q;
    ids_d         = ids_q;
    key_len_d     = key_len_q;
    last_addr_d   = last_addr_q;
    key_addr_d    = key_addr_q;
    key_wr_addr_d = key_wr_addr_q;
    key_wr_data_d = key_wr_data_q;
    key_wr_en_d   = 1'b0;
    init_data_d   = init_data_q;
    init_valid_d  = 1'b0;
    pkt_valid_d   = pkt_valid_q;
    err_d         = err_q | ovf;
    pop           = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop = 1'b1;
        if (hd_ctrl && hd_data[2:0] == 3'b001) begin
          init_data_d = hd_data[7:3];
          state_d     = ST_INIT_DUP;
        end else if (hd_ctrl && hd_data == 8'h00) begin
          byte_cnt_d = '0;
          state_d    = ST_CFG;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_INIT_DUP: if (!empty) begin
        pop          = 1'b1;
        init_valid_d = 1'b1;
        if (!hd_ctrl || hd_data != {init_data_q, 3'b001}) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_CFG, ST_IDS, ST_KEYLEN, ST_PAD: if (!empty) begin
        // A marker inside the body abandons the packet; the byte stays queued as a header.
        if (hd_ctrl) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pop        = 1'b1;
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (state_q == ST_CFG) begin
            cfg_d = {hd_data, cfg_q[191:8]};
            if (byte_cnt_q == 5'd23) begin
              byte_cnt_d = '0;
              state_d    = ST_IDS;
            end
          end else if (state_q == ST_IDS) begin
            ids_d = {hd_data, ids_q[63:8]};
            if (byte_cnt_q == 5'd7) begin
              byte_cnt_d = '0;
              state_d    = ST_KEYLEN;
            end
          end else if (state_q == ST_KEYLEN) begin
            key_len_d   = hd_data[AW:0];
            last_addr_d = (hd_data[AW-1:0] - AW'(1)) | AW'(3);
            if (int'(hd_data) > WORD_MAX_LEN) err_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = ST_PAD;
          end else if (byte_cnt_q == 5'd6) begin
            key_addr_d = '0;
            state_d    = ST_KEY;
          end
        end
      end
      ST_KEY: if (!empty) begin
        if (hd_ctrl && key_addr_q != last_addr_q) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pop           = 1'b1;
          key_wr_en_d   = 1'b1;
          key_wr_addr_d = key_addr_q;
          key_wr_data_d = hd_data;
          if (key_addr_q == last_addr_q) begin
            if (!hd_ctrl) err_d = 1'b1;
            pkt_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            key_addr_d = key_addr_q + AW'(1);
          end
        end
      end
      ST_DONE: if (pkt_ack) begin
        pkt_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      cfg_q         <= '0;
      ids_q         <= '0;
      key_len_q     <= '0;
      last_addr_q   <= '0;
      key_addr_q    <= '0;
      key_wr_addr_q <= '0;
      key_wr_data_q <= '0;
      key_wr_en_q   <= 1'b0;
      init_data_q   <= '0;
      init_valid_q  <= 1'b0;
      pkt_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      in_afull_q    <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      cfg_q         <= cfg_d;
      ids_q         <= ids_d;
      key_len_q     <= key_len_d;
      last_addr_q   <= last_addr_d;
      key_addr_q    <= key_addr_d;
      key_wr_addr_q <= key_wr_addr_d;
      key_wr_data_q <= key_wr_data_d;
      key_wr_en_q   <= key_wr_en_d;
      init_data_q   <= init_data_d;
      init_valid_q  <= init_valid_d;
      pkt_valid_q   <= pkt_valid_d;
      err_q         <= err_d;
      in_afull_q    <= (count >= AFULL_C);
      in_ready_q    <= (state_q == ST_IDLE) & empty & ~pkt_valid_q;
    end
  end

  assign in_afull    = in_afull_q;
  assign in_ready    = in_ready_q;
  assign cfg_cnt     = cfg_q[31:0];
  assign salt_len    = cfg_q[63:32];
  assign salt        = cfg_q[191:64];
  assign ids         = ids_q;
  assign key_len     = key_len_q;
  assign key_wr_en   = key_wr_en_q;
  assign key_wr_addr = key_wr_addr_q;
  assign key_wr_data = key_wr_data_q;
  assign pkt_valid   = pkt_valid_q;
  assign init_valid  = init_valid_q;
  assign init_data   = init_data_q;
  assign err         = err_q;
endmodule

// File: tb/tb_unit_pkt_rx.sv
// Directed bench for unit_pkt_rx: expected key writes and init events are queued
// as stimulus is driven and compared when the DUT emits them.
module tb_unit_pkt_rx;
  logic         CLK = 1'b0, RST_N = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_ctrl = 1'b0, in_wr_en = 1'b0, pkt_ack = 1'b0;
  logic         in_afull, in_ready, key_wr_en, pkt_valid, init_valid, err;
  logic [31:0]  cfg_cnt, salt_len;
  logic [127:0] salt;
  logic [63:0]  ids;
  logic [6:0]   key_len;
  logic [5:0]   key_wr_addr;
  logic [7:0]   key_wr_data;
  logic [4:0]   init_data;

  int checks = 0;
  int errors = 0;
  logic [14:0] kq[$];   // {pkt_valid expected, addr, data}
  logic [4:0]  iq[$];

  unit_pkt_rx #(.WORD_MAX_LEN(64), .FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr_en(in_wr_en),
    .in_afull(in_afull), .in_ready(in_ready), .cfg_cnt(cfg_cnt), .salt_len(salt_len),
    .salt(salt), .ids(ids), .key_len(key_len), .key_wr_en(key_wr_en),
    .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data), .pkt_valid(pkt_valid),
    .pkt_ack(pkt_ack), .init_valid(init_valid), .init_data(init_data), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1 && key_wr_en === 1'b1) begin
      checks++;
      assert (kq.size() != 0) else begin
        errors++;
        $error("FAIL key_unexpected observed=%0h/%0h expected=none", key_wr_addr, key_wr_data);
      end
      if (kq.size() != 0) chk("key_wr", {pkt_valid, key_wr_addr, key_wr_data}, kq.pop_front());
    end
    if (RST_N === 1'b1 && init_valid === 1'b1) begin
      checks++;
      assert (iq.size() != 0) else begin
        errors++;
        $error("FAIL init_unexpected observed=%0h expected=none", init_data);
      end
      if (iq.size() != 0) chk("init_data", init_data, iq.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic c);
    in_data = d; in_ctrl = c; in_wr_en = 1'b1;
    cyc(1);
    in_wr_en = 1'b0; in_ctrl = 1'b0;
  endtask

  task automatic send_init(input logic [7:0] d);
    push(d, 1'b1);
    push(d, 1'b1);
    iq.push_back(d[7:3]);
  endtask

  task automatic send_head(input int nbytes);
    push(8'h00, 1'b1);
    for (int i = 0; i < 24 && i + 1 < nbytes; i++) push(8'(i), 1'b0);
    for (int i = 0; i < 8 && i + 25 < nbytes; i++) push(8'(8'h30 + i), 1'b0);
  endtask

  // bad_idx >= 0 stops before that key byte so the caller can inject a marker.
  task automatic send_pkt(input logic [7:0] klen, input int nkey, input int bad_idx);
    logic c;
    send_head(33);
    push(klen, 1'b0);
    for (int i = 0; i < 7; i++) push(8'hEE, 1'b0);
    for (int i = 0; i < nkey; i++) begin
      if (i == bad_idx) break;
      c = (i == nkey - 1);
      push(8'(8'h40 + i), c);
      kq.push_back({c, 6'(i), 8'(8'h40 + i)});
    end
  endtask

  task automatic wait_pkt(input int max);
    int n = 0;
    while (pkt_valid !== 1'b1 && n < max) begin cyc(1); n++; end
    chk("pkt_valid_rise", pkt_valid, 1'b1);
  endtask

  task automatic ack_pkt();
    pkt_ack = 1'b1;
    cyc(1);
    pkt_ack = 1'b0;
    chk("pkt_valid_drop", pkt_valid, 1'b0);
  endtask

  task automatic drain(input int max);
    int n = 0;
    cyc(3);
    while (in_ready !== 1'b1 && n < max) begin cyc(1); n++; end
    chk("in_ready_idle", in_ready, 1'b1);
    cyc(2);
    chk("key_queue_empty", kq.size(), 0);
    chk("init_queue_empty", iq.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_afull", in_afull, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_init_valid", init_valid, 1'b0);
    chk("rst_key_wr_en", key_wr_en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cfg", {salt, salt_len, cfg_cnt}, '0);
    chk("rst_ids", ids, '0);
    chk("rst_key", {key_len, key_wr_addr, key_wr_data, init_data}, '0);
  endtask

  task automatic release_reset();
    cyc(1);
    RST_N = 1'b1;
    chk("in_ready_at_release", in_ready, 1'b0);
    cyc(1);
    chk("in_ready_after_release", in_ready, 1'b1);
  endtask

  task automatic do_reset();
    in_wr_en = 1'b0;
    RST_N = 1'b0;
    #1;
    chk_reset_outputs();
    release_reset();
  endtask

  task automatic chk_fields(input logic [6:0] klen);
    chk("cfg_cnt", cfg_cnt, 32'h03020100);
    chk("salt_len", salt_len, 32'h07060504);
    chk("salt_lsb", salt[7:0], 8'h08);
    chk("salt", salt, 128'h17161514131211100F0E0D0C0B0A0908);
    chk("ids", ids, 64'h3736353433323130);
    chk("key_len", key_len, klen);
  endtask

  initial begin
    #1;
    chk_reset_outputs();
    cyc(1);
    release_reset();

    // init packet
    send_init(8'h29);
    drain(50);
    chk("init_err", err, 1'b0);

    // data packet, key_len=5 -> 8 key writes
    send_pkt(8'd5, 8, -1);
    wait_pkt(100);
    chk_fields(7'd5);
    cyc(5);
    chk("pkt_valid_hold", pkt_valid, 1'b1);
    ack_pkt();
    drain(50);
    chk("pkt_err", err, 1'b0);

    // stray byte in IDLE, then a valid init
    push(8'h55, 1'b0);
    cyc(2);
    chk("stray_err", err, 1'b1);
    send_init(8'h29);
    drain(50);

    // key_len=0 -> 64 key bytes
    do_reset();
    send_pkt(8'd0, 64, -1);
    wait_pkt(200);
    chk_fields(7'd0);
    chk("klen0_err", err, 1'b0);
    ack_pkt();
    drain(50);

    // key_len=4 with marker on 3rd key byte: abort, byte reparsed as init header
    send_pkt(8'd4, 4, 2);
    send_init(8'h29);
    drain(50);
    chk("early_marker_err", err, 1'b1);
    chk("early_marker_pkt_valid", pkt_valid, 1'b0);

    // backpressure while parser is held in DONE
    do_reset();
    send_pkt(8'd5, 8, -1);
    wait_pkt(100);
    for (int k = 1; k <= 20; k++) begin
      push(8'h29, 1'b1);
      if (k <= 16 && k % 2 == 0) iq.push_back(5'd5);
      if (k == 12) chk("afull_lag_12", in_afull, 1'b0);
      if (k == 13) chk("afull_13", in_afull, 1'b1);
      if (k == 16) chk("no_ovf_err_16", err, 1'b0);
      if (k == 17) chk("ovf_err_17", err, 1'b1);
    end
    ack_pkt();
    drain(100);
    chk("afull_cleared", in_afull, 1'b0);

    // async reset at the 30th byte of a packet, then a full packet
    do_reset();
    send_pkt(8'd5, 8, -1);
    wait_pkt(100);
    ack_pkt();
    drain(50);
    send_head(29);
    in_data = 8'h34; in_ctrl = 1'b0; in_wr_en = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    in_wr_en = 1'b0;
    chk_reset_outputs();
    release_reset();
    send_pkt(8'd5, 8, -1);
    wait_pkt(100);
    chk_fields(7'd5);
    chk("post_reset_err", err, 1'b0);
    ack_pkt();
    drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
